button_pulse_conditioner: RTL and testbench



---
 rtl/button_pulse_conditioner.sv | 128 ++++++++++++
 tb/tb_button_pulse_conditioner.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_pulse_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM, one registered
// enable pulse per accepted press. Optional auto-repeat under `BTN_AUTOREPEAT_EN.
module button_pulse_conditioner #(
    parameter int CNT_W           = 20,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RPT_W           = 25,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    output logic       enable_pulse,
    output logic       btn_level,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        PRESS_CHK   = 2'b01,
        PRESSED     = 2'b10,
        RELEASE_CHK = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state, state_n;
    logic             sync1, sync2;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             level_n, press_pulse, rpt_pulse;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1        <= 1'b0;
            sync2        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            btn_level    <= 1'b0;
            enable_pulse <= 1'b0;
        end else begin
            sync1        <= btn_raw;
            sync2        <= sync1;
            state        <= state_n;
            cnt          <= cnt_n;
            btn_level    <= level_n;
            enable_pulse <= press_pulse | rpt_pulse;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        level_n     = btn_level;
        press_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) begin
                    state_n = PRESS_CHK;
                    cnt_n   = CNT_W'(1);
                end else begin
                    cnt_n   = '0;
                end
            end
            PRESS_CHK: begin
                if (!sync2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n     = PRESSED;
                    level_n     = 1'b1;
                    press_pulse = 1'b1;
                    cnt_n       = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!sync2) begin
                    state_n = RELEASE_CHK;
                    cnt_n   = CNT_W'(1);
                end
            end
            RELEASE_CHK: begin
                // A high sample mid-release is contact bounce: go back without a pulse.
                if (sync2) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    level_n = 1'b0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_CYCLES - 1);

    logic [RPT_W-1:0] rcnt;

    // Counts only while settled in PRESSED; any excursion restarts the period.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rcnt <= '0;
        end else if (state == PRESSED) begin
            rcnt <= (rcnt == RPT_LAST) ? '0 : rcnt + RPT_W'(1);
        end else begin
            rcnt <= '0;
        end
    end

    assign rpt_pulse = (state == PRESSED) && (rcnt == RPT_LAST);
`else
    assign rpt_pulse = 1'b0;

    if (RPT_W < 1 || REPEAT_CYCLES < 2) begin : g_rpt_cfg_unused
    end
`endif

    assign state_dbg = state;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench: expected pulse edges are queued when stimulus is driven and
// matched against pulses captured by a monitor. DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
module tb_button_pulse_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_raw;
    logic       enable_pulse;
    logic       btn_level;
    logic [1:0] state_dbg;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int exp_q[$];
    int obs_q[$];

    button_pulse_conditioner #(
        .CNT_W(4), .DEBOUNCE_CYCLES(4), .RPT_W(4), .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .enable_pulse(enable_pulse), .btn_level(btn_level), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (enable_pulse === 1'b1) obs_q.push_back(cyc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        btn_raw = 1'b0;
        reset   = 1'b1;
        repeat (12) tick();
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic test_reset();
        int base, e, o;
        reset   = 1'b0;
        btn_raw = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            tests++;
            if (enable_pulse !== 1'b0 || btn_level !== 1'b0 || state_dbg !== 2'b00) begin
                fails++;
                $display("FAIL reset_hold k=%0d: pulse=%b level=%b state=%b, want 0 0 00",
                         k, enable_pulse, btn_level, state_dbg);
            end
        end
        reset = 1'b1;
        base  = cyc;
        exp_q.push_back(base + 6);
        repeat (10) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL reset_pulse: missing pulse, want edge %0d", e - base);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL reset_pulse: got edge %0d, want edge %0d", o - base, e - base);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL reset_extra: unexpected pulse at edge %0d", obs_q[0] - base);
        end
    endtask

    task automatic test_clean_press();
        int base, e, o;
        base = cyc;
        exp_q.push_back(base + 6);
`ifdef BTN_AUTOREPEAT_EN
        exp_q.push_back(base + 14);
        exp_q.push_back(base + 22);
`endif
        for (int k = 1; k <= 24; k++) begin
            btn_raw = (k <= 20);
            tick();
            if (k == 5) begin
                tests++;
                if (btn_level !== 1'b0) begin
                    fails++;
                    $display("FAIL press_level_early: level=%b want 0", btn_level);
                end
            end
            if (k >= 6 && k <= 20) begin
                tests++;
                if (btn_level !== 1'b1) begin
                    fails++;
                    $display("FAIL press_level k=%0d: level=%b want 1", k, btn_level);
                end
            end
            if (k == 6) begin
                tests++;
                if (state_dbg !== 2'b10) begin
                    fails++;
                    $display("FAIL press_state: state=%b want 10", state_dbg);
                end
            end
        end
        btn_raw = 1'b0;
        repeat (8) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL press_pulse: missing pulse, want edge %0d", e - base);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL press_pulse: got edge %0d, want edge %0d", o - base, e - base);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL press_extra: unexpected pulse at edge %0d", obs_q[0] - base);
        end
    endtask

    task automatic test_bounce_reject();
        int base;
        base = cyc;
        for (int r = 0; r < 5; r++) begin
            for (int p = 0; p < 4; p++) begin
                btn_raw = (p != 3);
                tick();
                tests++;
                if ((state_dbg !== 2'b00 && state_dbg !== 2'b01) || btn_level !== 1'b0) begin
                    fails++;
                    $display("FAIL bounce_state r=%0d p=%0d: state=%b level=%b, want 00/01 and 0",
                             r, p, state_dbg, btn_level);
                end
            end
        end
        btn_raw = 1'b0;
        repeat (6) tick();
        tests++;
        if (obs_q.size() != 0 || exp_q.size() != 0) begin
            fails++;
            $display("FAIL bounce_pulse: %0d pulses seen (first at edge %0d), want 0",
                     obs_q.size(), (obs_q.size() != 0) ? obs_q[0] - base : 0);
        end
    endtask

    task automatic test_release_bounce();
        int base, e, o;
        base = cyc;
        exp_q.push_back(base + 6);
        for (int k = 1; k <= 16; k++) begin
            btn_raw = !(k == 11 || k == 12);
            tick();
            if (k >= 6) begin
                tests++;
                if (btn_level !== 1'b1) begin
                    fails++;
                    $display("FAIL relbounce_level k=%0d: level=%b want 1", k, btn_level);
                end
            end
        end
        tests++;
        if (state_dbg !== 2'b10) begin
            fails++;
            $display("FAIL relbounce_state: state=%b want 10", state_dbg);
        end
        btn_raw = 1'b0;
        repeat (10) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL relbounce_pulse: missing pulse, want edge %0d", e - base);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL relbounce_pulse: got edge %0d, want edge %0d", o - base, e - base);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL relbounce_extra: unexpected pulse at edge %0d", obs_q[0] - base);
        end
    endtask

    task automatic test_full_release();
        int base, e, o;
        base = cyc;
        exp_q.push_back(base + 6);
        for (int k = 1; k <= 20; k++) begin
            btn_raw = (k <= 10);
            tick();
            if (k == 15) begin
                tests++;
                if (btn_level !== 1'b1) begin
                    fails++;
                    $display("FAIL release_level_early: level=%b want 1", btn_level);
                end
            end
            if (k >= 16) begin
                tests++;
                if (btn_level !== 1'b0 || state_dbg !== 2'b00) begin
                    fails++;
                    $display("FAIL release_done k=%0d: level=%b state=%b, want 0 00",
                             k, btn_level, state_dbg);
                end
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL release_pulse: missing pulse, want edge %0d", e - base);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL release_pulse: got edge %0d, want edge %0d", o - base, e - base);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL release_extra: unexpected pulse at edge %0d", obs_q[0] - base);
        end
    endtask

    task automatic test_mid_reset();
        int base, e, o;
        btn_raw = 1'b1;
        repeat (4) tick();
        tests++;
        if (state_dbg !== 2'b01) begin
            fails++;
            $display("FAIL midreset_pre: state=%b want 01", state_dbg);
        end
        reset = 1'b0;
        tick();
        tests++;
        if (state_dbg !== 2'b00 || enable_pulse !== 1'b0 || btn_level !== 1'b0) begin
            fails++;
            $display("FAIL midreset_clear: state=%b pulse=%b level=%b, want 00 0 0",
                     state_dbg, enable_pulse, btn_level);
        end
        reset = 1'b1;
        base  = cyc;
        exp_q.push_back(base + 6);
        repeat (9) tick();
        btn_raw = 1'b0;
        repeat (10) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_q.size() == 0) begin
                fails++;
                $display("FAIL midreset_pulse: missing pulse, want edge %0d", e - base);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    fails++;
                    $display("FAIL midreset_pulse: got edge %0d, want edge %0d", o - base, e - base);
                end
            end
        end
        tests++;
        if (obs_q.size() != 0) begin
            fails++;
            $display("FAIL midreset_extra: unexpected pulse at edge %0d", obs_q[0] - base);
        end
    endtask

    initial begin
        reset   = 1'b0;
        btn_raw = 1'b0;
        repeat (2) tick();
        test_reset();
        settle();
        test_clean_press();
        settle();
        test_bounce_reject();
        settle();
        test_release_bounce();
        settle();
        test_full_release();
        settle();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
